seg7_scan_driver: RTL and testbench

//   Time-multiplexed driver for the 4-digit common-anode seven-segment display.

---
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scanner with a double-buffered load port.
// New display contents are swapped in only at a frame boundary, so a frame never mixes old and new digits.
module seg7_scan_driver #(
  parameter int PRESCALE_BITS = 17,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic        CLK100MHZ,
  input  logic        RESET,
  input  logic [15:0] VALUE,
  input  logic [3:0]  DOTS,
  input  logic [3:0]  DIGIT_EN,
  input  logic        LOAD,
  output logic        LOAD_READY,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME_TICK
);

  localparam logic [PRESCALE_BITS-1:0] BLANK_P = PRESCALE_BITS'(BLANK_CYCLES);

  logic [PRESCALE_BITS-1:0] cnt_p0;
  logic [1:0]               idx_p0;
  logic [15:0]              act_value;
  logic [15:0]              shd_value;
  logic [3:0]               act_dots;
  logic [3:0]               shd_dots;
  logic [3:0]               act_en;
  logic [3:0]               shd_en;
  logic                     pending;

  logic                     slot_end_p0;
  logic                     frame_end_p0;
  logic                     load_acc;
  logic                     lit_p0;
  logic [3:0]               nib_p0;

  logic [3:0]               an_p1;
  logic [6:0]               seg_p1;
  logic                     dp_p1;
  logic                     tick_p1;

  function automatic logic [6:0] dec7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Stage p0: prescaler, digit index and the decode inputs for the current slot
  always_comb begin
    slot_end_p0  = (cnt_p0 == {PRESCALE_BITS{1'b1}});
    frame_end_p0 = slot_end_p0 && (idx_p0 == 2'd3);
    load_acc     = LOAD && !pending;
    lit_p0       = (cnt_p0 >= BLANK_P) && act_en[idx_p0];
    nib_p0       = act_value[{idx_p0, 2'b00} +: 4];
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      cnt_p0 <= '0;
      idx_p0 <= 2'd0;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
      if (slot_end_p0) idx_p0 <= idx_p0 + 2'd1;
    end
  end

  // A load taken on the frame_end cycle cannot be swapped in on that same edge: pending was 0 then.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      shd_value <= '0;
      shd_dots  <= '0;
      shd_en    <= '0;
      act_value <= '0;
      act_dots  <= '0;
      act_en    <= '0;
      pending   <= 1'b0;
    end else if (load_acc) begin
      shd_value <= VALUE;
      shd_dots  <= DOTS;
      shd_en    <= DIGIT_EN;
      pending   <= 1'b1;
    end else if (frame_end_p0 && pending) begin
      act_value <= shd_value;
      act_dots  <= shd_dots;
      act_en    <= shd_en;
      pending   <= 1'b0;
    end
  end

  // Stage p1: registered pin drivers
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      an_p1   <= 4'hF;
      seg_p1  <= 7'h7F;
      dp_p1   <= 1'b1;
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= frame_end_p0;
      if (lit_p0) begin
        an_p1  <= ~(4'b0001 << idx_p0);
        seg_p1 <= dec7(nib_p0);
        dp_p1  <= ~act_dots[idx_p0];
      end else begin
        an_p1  <= 4'hF;
        seg_p1 <= 7'h7F;
        dp_p1  <= 1'b1;
      end
    end
  end

  assign AN         = an_p1;
  assign SEG        = seg_p1;
  assign DP         = dp_p1;
  assign FRAME_TICK = tick_p1;
  assign LOAD_READY = ~pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 16-clock slot and 2-clock blanking.
// Positions are tracked relative to FRAME_TICK: slot s, count c shows at tick + 1 + 16*s + c.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dots;
  logic [3:0]  digit_en;
  logic        load;
  logic        load_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .PRESCALE_BITS(4),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .VALUE     (value),
    .DOTS      (dots),
    .DIGIT_EN  (digit_en),
    .LOAD      (load),
    .LOAD_READY(load_ready),
    .AN        (an),
    .SEG       (seg),
    .DP        (dp),
    .FRAME_TICK(frame_tick)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL sync_tick frame_tick=%b after %0d cycles, required 1", frame_tick, n);
    end
  endtask

  task automatic test_reset();
    int lit;
    int n;
    rst = 1'b1; load = 1'b0; value = '0; dots = '0; digit_en = '0;
    step(2);
    checks += 5;
    if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h required=F", an); end
    if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h required=7F", seg); end
    if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b required=1", dp); end
    if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", load_ready); end
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b required=0", frame_tick); end
    rst = 1'b0;
    lit = 0;
    for (int k = 0; k < 70; k++) begin
      step(1);
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) lit++;
    end
    checks++;
    if (lit != 0) begin failures++; $display("FAIL reset_dark lit_cycles=%0d required=0", lit); end
    sync_tick();
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    checks++;
    if (n != 64) begin failures++; $display("FAIL tick_period got=%0d required=64", n); end
    step(1);
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL tick_width got=%b required=0", frame_tick); end
  endtask

  task automatic test_load();
    logic [3:0] ean [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] eseg[4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic       edp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    sync_tick();
    step(4);
    value = 16'h1234; dots = 4'b0001; digit_en = 4'hF; load = 1'b1;
    step(1);
    value = 16'hFFFF;
    checks++;
    if (load_ready !== 1'b0) begin failures++; $display("FAIL load_ready_low got=%b required=0", load_ready); end
    step(1);
    load = 1'b0; value = '0;
    step(57);
    checks++;
    if (load_ready !== 1'b0 || frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL load_pre_frame_end ready=%b tick=%b required ready=0 tick=0", load_ready, frame_tick);
    end
    step(1);
    checks++;
    if (load_ready !== 1'b1 || frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL load_swap ready=%b tick=%b required ready=1 tick=1", load_ready, frame_tick);
    end
    for (int s = 0; s < 4; s++) begin
      step(1);
      checks++;
      if (an !== 4'hF) begin failures++; $display("FAIL load_blank0 slot=%0d an=%h required=F", s, an); end
      step(1);
      checks++;
      if (an !== 4'hF) begin failures++; $display("FAIL load_blank1 slot=%0d an=%h required=F", s, an); end
      step(1);
      checks++;
      if (an !== ean[s] || seg !== eseg[s] || dp !== edp[s]) begin
        failures++;
        $display("FAIL load_slot slot=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 s, an, seg, dp, ean[s], eseg[s], edp[s]);
      end
      step(13);
    end
  endtask

  task automatic test_ignore();
    logic [3:0] ean [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] eseg[4] = '{7'h00, 7'h78, 7'h02, 7'h12};
    logic       edp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    sync_tick();
    step(4);
    value = 16'h5678; dots = 4'b1000; digit_en = 4'hF; load = 1'b1;
    step(1);
    value = 16'hFFFF; dots = 4'b0000;
    checks++;
    if (load_ready !== 1'b0) begin failures++; $display("FAIL ignore_ready got=%b required=0", load_ready); end
    step(1);
    load = 1'b0;
    step(48);
    checks++;
    if (an !== 4'h7 || seg !== 7'h79 || dp !== 1'b1) begin
      failures++;
      $display("FAIL ignore_old_slot3 an=%h seg=%h dp=%b required an=7 seg=79 dp=1", an, seg, dp);
    end
    step(10);
    checks++;
    if (load_ready !== 1'b1 || frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL ignore_swap ready=%b tick=%b required ready=1 tick=1", load_ready, frame_tick);
    end
    for (int s = 0; s < 4; s++) begin
      step(3);
      checks++;
      if (an !== ean[s] || seg !== eseg[s] || dp !== edp[s]) begin
        failures++;
        $display("FAIL ignore_slot slot=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 s, an, seg, dp, ean[s], eseg[s], edp[s]);
      end
      step(13);
    end
  endtask

  task automatic test_enable();
    logic [3:0] ean [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [6:0] eseg[4] = '{7'h21, 7'h46, 7'h7F, 7'h7F};
    logic       edp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    sync_tick();
    step(4);
    value = 16'hABCD; dots = 4'hF; digit_en = 4'b0011; load = 1'b1;
    step(1);
    load = 1'b0;
    step(59);
    checks++;
    if (load_ready !== 1'b1 || frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL enable_swap ready=%b tick=%b required ready=1 tick=1", load_ready, frame_tick);
    end
    for (int s = 0; s < 4; s++) begin
      step(3);
      checks++;
      if (an !== ean[s] || seg !== eseg[s] || dp !== edp[s]) begin
        failures++;
        $display("FAIL enable_slot slot=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 s, an, seg, dp, ean[s], eseg[s], edp[s]);
      end
      step(13);
    end
  endtask

  task automatic test_coincident();
    sync_tick();
    step(63);
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL coinc_ready_pre got=%b required=1", load_ready); end
    value = 16'h8888; dots = 4'h0; digit_en = 4'hF; load = 1'b1;
    step(1);
    load = 1'b0;
    checks++;
    if (frame_tick !== 1'b1 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL coinc_accept tick=%b ready=%b required tick=1 ready=0", frame_tick, load_ready);
    end
    step(1);
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL coinc_tick_width got=%b required=0", frame_tick); end
    step(2);
    checks++;
    if (an !== 4'hE || seg !== 7'h21) begin
      failures++;
      $display("FAIL coinc_old_frame an=%h seg=%h required an=E seg=21", an, seg);
    end
    step(61);
    checks++;
    if (frame_tick !== 1'b1 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL coinc_swap tick=%b ready=%b required tick=1 ready=1", frame_tick, load_ready);
    end
    step(3);
    checks++;
    if (an !== 4'hE || seg !== 7'h00 || dp !== 1'b1) begin
      failures++;
      $display("FAIL coinc_new_frame an=%h seg=%h dp=%b required an=E seg=00 dp=1", an, seg, dp);
    end
  endtask

  task automatic test_reset_mid();
    int lit;
    sync_tick();
    step(2);
    value = 16'h7777; dots = 4'hF; digit_en = 4'hF; load = 1'b1;
    step(1);
    load = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%b required=0", load_ready); end
    step(35);
    checks++;
    if (an !== 4'hB || seg !== 7'h00) begin
      failures++;
      $display("FAIL rmid_slot2 an=%h seg=%h required an=B seg=00", an, seg);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL rmid_reset an=%h seg=%h dp=%b ready=%b tick=%b required an=F seg=7F dp=1 ready=1 tick=0",
               an, seg, dp, load_ready, frame_tick);
    end
    lit = 0;
    for (int k = 0; k < 140; k++) begin
      step(1);
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) lit++;
    end
    checks++;
    if (lit != 0) begin failures++; $display("FAIL rmid_stale lit_cycles=%0d required=0", lit); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_ignore();
    test_enable();
    test_coincident();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
